// File: rtl/leon_feed_pkg.sv
// Shared definitions for the LEON instruction feeder.
//   NOP_WORD_DEF : SPARC "sethi 0,%g0", the default idle/padding word
//   feed_state_t : names which kind of word is currently on inst_data
//   clog2        : ceiling log2 used for pointer and level widths
package leon_feed_pkg;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0100_0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    PAD
  } feed_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/leon_inst_feeder_if.sv
// Push-side and fetch-side signals of the instruction feeder.
//   master : bench / core side (offers words, consumes inst_data)
//   slave  : feeder side
//   push_valid/push_data/push_ready : instruction push handshake
//   flush_i                         : synchronous clear request
//   fetch_en                        : core consumed inst_data this cycle
//   inst_data/inst_hold_n           : icache data word and hold (1 = no stall)
interface leon_inst_feeder_if;
  logic        push_valid;
  logic [31:0] push_data;
  logic        push_ready;
  logic        flush_i;
  logic        fetch_en;
  logic [31:0] inst_data;
  logic        inst_hold_n;

  modport master (
    output push_valid, push_data, flush_i, fetch_en,
    input  push_ready, inst_data, inst_hold_n
  );

  modport slave (
    input  push_valid, push_data, flush_i, fetch_en,
    output push_ready, inst_data, inst_hold_n
  );
endinterface

// File: rtl/leon_feed_fifo.sv
// Synchronous DEPTH x 32 FIFO, no bypass. Pointers carry a wrap bit so
// full/empty/level come straight from the pointer pair.
//   clk, rst (sync, active-low), clr (sync clear)
//   push/push_data : write when not full
//   pop/pop_data   : pop_data shows the head; pop advances when not empty
//   full, empty, level : occupancy status
module leon_feed_fifo
  import leon_feed_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [31:0]            push_data,
  input  logic                   pop,
  output logic [31:0]            pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]  mem_q [DEPTH];
  logic         do_push, do_pop;

  always_comb begin
    level    = wr_ptr_q - rd_ptr_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push && !full && !clr;
    do_pop   = pop && !empty && !clr;
    pop_data = mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/leon_inst_feeder.sv
// Instruction source standing in for the LEON icache. Each pushed word is
// presented for exactly one consumed fetch, then PAD_NOPS NOP words; NOP is
// driven whenever nothing is queued.
//   clk, rst (sync, active-low)
//   bus        : push handshake, flush, fetch_en, inst_data, inst_hold_n
//   fifo_level : FIFO occupancy
//   busy       : sequencer not idle or FIFO not empty
//   issued_cnt : non-NOP words consumed, wrapping
module leon_inst_feeder
  import leon_feed_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned PAD_NOPS       = 5,
  parameter logic [31:0] NOP_WORD       = NOP_WORD_DEF,
  parameter bit          STALL_ON_EMPTY = 1'b0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  leon_inst_feeder_if.slave      bus,
  output logic [clog2(DEPTH):0]  fifo_level,
  output logic                   busy,
  output logic [CNT_W-1:0]       issued_cnt
);

  feed_state_t      state_q, state_d;
  logic [31:0]      data_q, data_d;
  logic [3:0]       pad_q, pad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        full, empty, pop, push_fire, advance;
  logic [31:0] head;

  assign bus.push_ready = !full && !bus.flush_i;
  assign push_fire      = bus.push_valid && bus.push_ready;

  leon_feed_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.flush_i),
    .push      (push_fire),
    .push_data (bus.push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pad_d   = pad_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    advance = 1'b0;
    if (bus.flush_i) begin
      state_d = IDLE;
      data_d  = NOP_WORD;
      pad_d   = '0;
    end else if (bus.fetch_en) begin
      unique case (state_q)
        IDLE: advance = 1'b1;
        ISSUE: begin
          cnt_d = cnt_q + CNT_W'(1);
          // With no padding an issued word is followed directly by the
          // same pop-or-idle decision IDLE and exhausted PAD make.
          if (PAD_NOPS > 0) begin
            state_d = PAD;
            data_d  = NOP_WORD;
            pad_d   = 4'(PAD_NOPS - 1);
          end else begin
            advance = 1'b1;
          end
        end
        PAD: begin
          if (pad_q != '0) pad_d = pad_q - 4'd1;
          else             advance = 1'b1;
        end
        default: advance = 1'b1;
      endcase
      if (advance) begin
        if (!empty) begin
          pop     = 1'b1;
          data_d  = head;
          state_d = ISSUE;
        end else begin
          data_d  = NOP_WORD;
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= NOP_WORD;
      pad_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pad_q   <= pad_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.inst_data   = data_q;
  assign bus.inst_hold_n = !(STALL_ON_EMPTY && (state_q == IDLE) && empty);
  assign busy            = (state_q != IDLE) || !empty;
  assign issued_cnt      = cnt_q;

endmodule
